// File: rtl/bin2digit.sv
// Signed binary to 7-segment display codes (0-9 digit, 10 blank, 11 minus) via iterative double-dabble.
// Build option: define BIN2DIGIT_BLANK_LZ_EN to blank leading zeros and float the minus sign.
module bin2digit #(
    parameter int WIDTH = 16,
    parameter int NDIG  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    value,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic [4*NDIG-1:0]   digits
);

    localparam int NBCD = (WIDTH + 2) / 3;
    localparam int NPAD = (NDIG > NBCD) ? NDIG : NBCD;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_MINUS = 4'd11;

    typedef enum logic [1:0] {IDLE, SHIFT, FMT} state_t;

    state_t              state_reg, state_next;
    logic                sign_reg, sign_next;
    logic [WIDTH-1:0]    mag_reg, mag_next;
    logic [4*NBCD-1:0]   bcd_reg, bcd_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [4*NDIG-1:0]   digits_reg, digits_next;
    logic                ovf_reg, ovf_next;
    logic                done_reg, done_next;

    logic [4*NBCD-1:0]   bcd_adj;
    logic [4*NPAD-1:0]   bcd_pad;
    logic [NPAD-1:0]     upper_nz;
    logic                ovf_calc;
    logic [4*NDIG-1:0]   fmt;

    // Double-dabble correction: any nibble >= 5 would carry past 9 after the shift.
    generate
        for (genvar gi = 0; gi < NBCD; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        bcd_pad = '0;
        bcd_pad[4*NBCD-1:0] = bcd_reg;
    end

    generate
        for (genvar gi = 0; gi < NPAD; gi++) begin : g_upper
            if (gi >= NDIG) begin : g_hi
                assign upper_nz[gi] = |bcd_pad[4*gi +: 4];
            end else begin : g_lo
                assign upper_nz[gi] = 1'b0;
            end
        end
    endgenerate

    // A negative result also needs the leftmost position free for the minus sign.
    assign ovf_calc = (|upper_nz) | (sign_reg & (|bcd_pad[4*(NDIG-1) +: 4]));

`ifdef BIN2DIGIT_BLANK_LZ_EN
    logic [NDIG-1:0] shown;
    logic            acc;

    always_comb begin
        acc   = 1'b0;
        shown = '0;
        fmt   = {NDIG{CODE_BLANK}};
        for (int i = NDIG - 1; i >= 0; i--) begin
            acc      = acc | (|bcd_pad[4*i +: 4]);
            shown[i] = acc | (i == 0);
        end
        for (int i = 0; i < NDIG; i++) begin
            if (shown[i]) begin
                fmt[4*i +: 4] = bcd_pad[4*i +: 4];
            end
        end
        // Minus goes in the first blank position left of the leading digit.
        for (int i = 1; i < NDIG; i++) begin
            if (sign_reg && !shown[i] && shown[i-1]) begin
                fmt[4*i +: 4] = CODE_MINUS;
            end
        end
        if (ovf_calc) begin
            fmt = {NDIG{CODE_MINUS}};
        end
    end
`else
    always_comb begin
        fmt = bcd_pad[4*NDIG-1:0];
        if (sign_reg) begin
            fmt[4*(NDIG-1) +: 4] = CODE_MINUS;
        end
        if (ovf_calc) begin
            fmt = {NDIG{CODE_MINUS}};
        end
    end
`endif

    always_comb begin
        state_next  = state_reg;
        sign_next   = sign_reg;
        mag_next    = mag_reg;
        bcd_next    = bcd_reg;
        cnt_next    = cnt_reg;
        digits_next = digits_reg;
        ovf_next    = ovf_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    sign_next  = value[WIDTH-1];
                    mag_next   = value[WIDTH-1] ? -value : value;
                    bcd_next   = '0;
                    cnt_next   = CW'(WIDTH);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_next, mag_next} = {bcd_adj, mag_reg} << 1;
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = FMT;
                end
            end
            FMT: begin
                digits_next = fmt;
                ovf_next    = ovf_calc;
                done_next   = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            sign_reg   <= 1'b0;
            mag_reg    <= '0;
            bcd_reg    <= '0;
            cnt_reg    <= '0;
            digits_reg <= {NDIG{CODE_BLANK}};
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sign_reg   <= sign_next;
            mag_reg    <= mag_next;
            bcd_reg    <= bcd_next;
            cnt_reg    <= cnt_next;
            digits_reg <= digits_next;
            ovf_reg    <= ovf_next;
            done_reg   <= done_next;
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = done_reg;
    assign ovf    = ovf_reg;
    assign digits = digits_reg;

endmodule

// File: tb/tb_bin2digit.sv
// Table-driven bench for bin2digit: a 6-position and a 4-position instance run side by side.
module tb_bin2digit;

`ifdef BIN2DIGIT_BLANK_LZ_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] v;
        logic [23:0] on6;
        logic [23:0] off6;
        logic        ovf6;
        logic [15:0] on4;
        logic [15:0] off4;
        logic        ovf4;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] value;
    logic        busy6, done6, ovf6, busy4, done4, ovf4;
    logic [23:0] digits6;
    logic [15:0] digits4;

    int n_checks = 0;
    int n_pass   = 0;

    bin2digit #(.WIDTH(16), .NDIG(6)) dut6 (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy6), .done(done6), .ovf(ovf6), .digits(digits6)
    );

    bin2digit #(.WIDTH(16), .NDIG(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy4), .done(done4), .ovf(ovf4), .digits(digits4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Counts edges after the accepting edge until done; optionally injects a start pulse mid-way.
    task automatic wait_done(input int inj_at, input logic [15:0] inj_v,
                             input logic [23:0] held6, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (done6) seen = 1'b1;
            else begin
                if (n == 8) chk("held_digits6", {8'h0, digits6}, {8'h0, held6});
                if (n == inj_at) begin
                    start = 1'b1;
                    value = inj_v;
                end
            end
        end
    endtask

    task automatic check_result(input vec_t t, input int n);
        logic [23:0] e6;
        logic [15:0] e4;
        e6 = BLANK_ON ? t.on6 : t.off6;
        e4 = BLANK_ON ? t.on4 : t.off4;
        chk("latency", n, 17);
        chk("done4", {31'h0, done4}, 32'h1);
        chk("busy_at_done", {30'h0, busy6, busy4}, 32'h0);
        chk("digits6", {8'h0, digits6}, {8'h0, e6});
        chk("ovf6", {31'h0, ovf6}, {31'h0, t.ovf6});
        chk("digits4", {16'h0, digits4}, {16'h0, e4});
        chk("ovf4", {31'h0, ovf4}, {31'h0, t.ovf4});
        $display("conv value=%0d digits6=%h ovf6=%b digits4=%h ovf4=%b latency=%0d",
                 $signed(t.v), digits6, ovf6, digits4, ovf4, n);
    endtask

    task automatic do_conv(input vec_t t, input int inj_at, input logic [15:0] inj_v,
                           input logic [23:0] held6);
        int n;
        @(negedge clk);
        start = 1'b1;
        value = t.v;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", {30'h0, busy6, busy4}, 32'h3);
        wait_done(inj_at, inj_v, held6, n);
        check_result(t, n);
    endtask

    vec_t        vecs[11];
    vec_t        v5;
    logic [23:0] prev6;
    int          n;
    int          pulses;

    initial begin
        vecs[0]  = '{16'd1234,   24'hAA1234, 24'h001234, 1'b0, 16'h1234, 16'h1234, 1'b0};
        vecs[1]  = '{-16'sd45,   24'hAAAB45, 24'hB00045, 1'b0, 16'hAB45, 16'hB045, 1'b0};
        vecs[2]  = '{16'd0,      24'hAAAAA0, 24'h000000, 1'b0, 16'hAAA0, 16'h0000, 1'b0};
        vecs[3]  = '{16'h8000,   24'hB32768, 24'hB32768, 1'b0, 16'hBBBB, 16'hBBBB, 1'b1};
        vecs[4]  = '{16'd7,      24'hAAAAA7, 24'h000007, 1'b0, 16'hAAA7, 16'h0007, 1'b0};
        vecs[5]  = '{16'd9999,   24'hAA9999, 24'h009999, 1'b0, 16'h9999, 16'h9999, 1'b0};
        vecs[6]  = '{16'd10000,  24'hA10000, 24'h010000, 1'b0, 16'hBBBB, 16'hBBBB, 1'b1};
        vecs[7]  = '{-16'sd1000, 24'hAB1000, 24'hB01000, 1'b0, 16'hBBBB, 16'hBBBB, 1'b1};
        vecs[8]  = '{-16'sd999,  24'hAAB999, 24'hB00999, 1'b0, 16'hB999, 16'hB999, 1'b0};
        vecs[9]  = '{16'd32767,  24'hA32767, 24'h032767, 1'b0, 16'hBBBB, 16'hBBBB, 1'b1};
        vecs[10] = '{-16'sd1,    24'hAAAAB1, 24'hB00001, 1'b0, 16'hAAB1, 16'hB001, 1'b0};
        v5       = '{16'd5,      24'hAAAAA5, 24'h000005, 1'b0, 16'hAAA5, 16'h0005, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {30'h0, busy6, busy4}, 32'h0);
        chk("rst_done", {30'h0, done6, done4}, 32'h0);
        chk("rst_ovf", {30'h0, ovf6, ovf4}, 32'h0);
        chk("rst_digits6", {8'h0, digits6}, 32'h00AAAAAA);
        chk("rst_digits4", {16'h0, digits4}, 32'h0000AAAA);
        @(negedge clk);
        rst = 1'b0;

        prev6 = 24'hAAAAAA;
        for (int i = 0; i < 11; i++) begin
            do_conv(vecs[i], -1, 16'd0, prev6);
            prev6 = BLANK_ON ? vecs[i].on6 : vecs[i].off6;
        end

        // Start during busy is ignored; start during the done cycle is accepted.
        do_conv(vecs[0], 5, 16'd5, prev6);
        prev6 = BLANK_ON ? vecs[0].on6 : vecs[0].off6;
        start = 1'b1;
        value = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accept", {31'h0, busy6}, 32'h1);
        wait_done(-1, 16'd0, prev6, n);
        check_result(v5, n);
        @(posedge clk); #1;
        chk("done_falls", {30'h0, done6, done4}, 32'h0);
        prev6 = BLANK_ON ? v5.on6 : v5.off6;

        // Reset 8 cycles into a conversion discards it.
        @(negedge clk);
        start = 1'b1;
        value = 16'd999;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", {30'h0, busy6, busy4}, 32'h0);
        chk("midrst_done", {30'h0, done6, done4}, 32'h0);
        chk("midrst_digits6", {8'h0, digits6}, 32'h00AAAAAA);
        chk("midrst_digits4", {16'h0, digits4}, 32'h0000AAAA);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done6 || done4) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        $display("reset mid-conversion: done pulses=%0d digits6=%h", pulses, digits6);
        do_conv(vecs[1], -1, 16'd0, 24'hAAAAAA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
